// File: rtl/axi_lite_master_bridge.sv
// Runs one arbitrated IF/MEM request as a single AXI4-Lite master transaction
// and returns a per-stage completion pulse with read data and error status.
module axi_lite_master_bridge #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rw_valid,
  input  logic                  rw_reqtype,
  input  logic                  rw_stage,
  input  logic [ADDR_W-1:0]     rw_addr,
  input  logic [DATA_W-1:0]     rw_wdata,
  input  logic [DATA_W/8-1:0]   rw_wstrb,
  output logic [DATA_W-1:0]     rw_rdata,
  output logic                  rw_err,
  output logic                  if_done,
  output logic                  mem_done,
  output logic                  busy,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_W-1:0]     awaddr,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_W-1:0]     araddr,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp
);

  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_REQ, WR_B, DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic                  stage_q, stage_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      stage_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      stage_q   <= stage_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    stage_d   = stage_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (rw_valid) begin
          addr_d  = rw_addr;
          wdata_d = rw_wdata;
          wstrb_d = rw_wstrb;
          stage_d = rw_stage;
          state_d = rw_reqtype ? WR_REQ : RD_AR;
        end
      end
      RD_AR: if (arready) state_d = RD_R;
      RD_R: begin
        if (rvalid) begin
          rdata_d = rdata;
          err_d   = (rresp != 2'b00);
          state_d = DONE;
        end
      end
      WR_REQ: begin
        // Flags accumulate so either channel may complete first or both together.
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) state_d = WR_B;
      end
      WR_B: begin
        if (bvalid) begin
          err_d   = (bresp != 2'b00);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    arvalid  = (state_q == RD_AR);
    rready   = (state_q == RD_R);
    awvalid  = (state_q == WR_REQ) && !aw_done_q;
    wvalid   = (state_q == WR_REQ) && !w_done_q;
    bready   = (state_q == WR_B);
    if_done  = (state_q == DONE) && !stage_q;
    mem_done = (state_q == DONE) && stage_q;
    busy     = (state_q != IDLE);
    araddr   = addr_q;
    awaddr   = addr_q;
    wdata    = wdata_q;
    wstrb    = wstrb_q;
    rw_rdata = rdata_q;
    rw_err   = err_q;
  end

endmodule
